// File: rtl/output_deskew.sv
// Output de-skew buffer for a 2x2 systolic array: collects the skewed
// bottom-of-column result words into a row-major 2x2 matrix and holds it
// until the consumer accepts it.
module output_deskew #(
   parameter int unsigned ACC_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             col1_valid,
   input  logic [ACC_W-1:0] col1_data,
   input  logic             col2_valid,
   input  logic [ACC_W-1:0] col2_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] c11,
   output logic [ACC_W-1:0] c12,
   output logic [ACC_W-1:0] c21,
   output logic [ACC_W-1:0] c22,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned ROW_W = 2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;

   localparam logic [ROW_W-1:0] ROW_0    = ROW_W'(0);
   localparam logic [ROW_W-1:0] ROW_1    = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(2);

   logic [1:0]       state_q, state_d;
   logic [ROW_W-1:0] r1_q, r1_d;
   logic [ROW_W-1:0] r2_q, r2_d;
   logic [ACC_W-1:0] c11_q, c11_d;
   logic [ACC_W-1:0] c12_q, c12_d;
   logic [ACC_W-1:0] c21_q, c21_d;
   logic [ACC_W-1:0] c22_q, c22_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   logic             any_valid;

   assign any_valid = col1_valid | col2_valid;

   // State and datapath registers; reset clears everything, including any partial matrix
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         r1_q        <= ROW_0;
         r2_q        <= ROW_0;
         c11_q       <= '0;
         c12_q       <= '0;
         c21_q       <= '0;
         c22_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         c11_q       <= c11_d;
         c12_q       <= c12_d;
         c21_q       <= c21_d;
         c22_q       <= c22_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state, per-column capture and drop detection
   always_comb begin
      state_d   = state_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      c11_d     = c11_q;
      c12_d     = c12_q;
      c21_d     = c21_q;
      c22_d     = c22_q;
      overrun_d = overrun_q;

      case (state_q)
         S_HOLD: begin
            if (out_ready) begin
               // Accepting edge: start a fresh matrix; a coincident strobe is row 0 of it
               r1_d    = ROW_0;
               r2_d    = ROW_0;
               state_d = S_IDLE;
               if (col1_valid) begin
                  c11_d = col1_data;
                  r1_d  = ROW_1;
               end
               if (col2_valid) begin
                  c12_d = col2_data;
                  r2_d  = ROW_1;
               end
               if (any_valid) begin
                  state_d = S_COLLECT;
               end
            end else if (any_valid) begin
               // Matrix still held: strobe has nowhere to go
               overrun_d = 1'b1;
            end
         end

         S_IDLE, S_COLLECT: begin
            // Column 1 fills c11 then c21
            if (col1_valid) begin
               if (r1_q == ROW_0) begin
                  c11_d = col1_data;
                  r1_d  = ROW_1;
               end else if (r1_q == ROW_1) begin
                  c21_d = col1_data;
                  r1_d  = ROW_FULL;
               end else begin
                  overrun_d = 1'b1;
               end
            end
            // Column 2 fills c12 then c22
            if (col2_valid) begin
               if (r2_q == ROW_0) begin
                  c12_d = col2_data;
                  r2_d  = ROW_1;
               end else if (r2_q == ROW_1) begin
                  c22_d = col2_data;
                  r2_d  = ROW_FULL;
               end else begin
                  overrun_d = 1'b1;
               end
            end
            if ((r1_d == ROW_FULL) && (r2_d == ROW_FULL)) begin
               state_d = S_HOLD;
            end else if ((r1_d != ROW_0) || (r2_d != ROW_0)) begin
               state_d = S_COLLECT;
            end
         end

         default: begin
            // Unreachable encoding: recover to an empty matrix
            state_d = S_IDLE;
            r1_d    = ROW_0;
            r2_d    = ROW_0;
         end
      endcase

      out_valid_d = (state_d == S_HOLD);
      busy_d      = (state_d == S_COLLECT);
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign c11       = c11_q;
   assign c12       = c12_q;
   assign c21       = c21_q;
   assign c22       = c22_q;

endmodule

// File: tb/tb_output_deskew.sv
// Directed scoreboard bench for output_deskew.
module tb_output_deskew;

   localparam int unsigned ACC_W = 16;

   typedef struct packed {
      logic [ACC_W-1:0] c11;
      logic [ACC_W-1:0] c12;
      logic [ACC_W-1:0] c21;
      logic [ACC_W-1:0] c22;
   } mat_t;

   logic             clk;
   logic             reset;
   logic             col1_valid;
   logic [ACC_W-1:0] col1_data;
   logic             col2_valid;
   logic [ACC_W-1:0] col2_data;
   logic             out_ready;
   logic             out_valid;
   logic [ACC_W-1:0] c11, c12, c21, c22;
   logic             busy;
   logic             overrun;

   int   checks = 0;
   int   errors = 0;
   mat_t sb[$];

   output_deskew #(.ACC_W(ACC_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .col1_valid (col1_valid),
      .col1_data  (col1_data),
      .col2_valid (col2_valid),
      .col2_data  (col2_data),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .c11        (c11),
      .c12        (c12),
      .c21        (c21),
      .c22        (c22),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v1, input logic [ACC_W-1:0] d1,
                        input logic v2, input logic [ACC_W-1:0] d2);
      col1_valid = v1;
      col1_data  = d1;
      col2_valid = v2;
      col2_data  = d2;
   endtask

   task automatic idle();
      drive(1'b0, 16'hDEAD, 1'b0, 16'hBEEF);
   endtask

   task automatic push(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                       input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
      mat_t m;
      m.c11 = a; m.c12 = b; m.c21 = c; m.c22 = d;
      sb.push_back(m);
   endtask

   // Compare outputs against the oldest expected matrix; optionally retire it
   task automatic compare_front(input string tag, input bit pop);
      mat_t m;
      check({tag, "_valid"}, ACC_W'(out_valid), ACC_W'(1));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, ACC_W'(0), ACC_W'(1));
      end else begin
         m = sb[0];
         check({tag, "_c11"}, c11, m.c11);
         check({tag, "_c12"}, c12, m.c12);
         check({tag, "_c21"}, c21, m.c21);
         check({tag, "_c22"}, c22, m.c22);
         if (pop) void'(sb.pop_front());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, ACC_W'(out_valid), ACC_W'(0));
      check({tag, "_busy"},      ACC_W'(busy),      ACC_W'(0));
      check({tag, "_overrun"},   ACC_W'(overrun),   ACC_W'(0));
      check({tag, "_c11"}, c11, ACC_W'(0));
      check({tag, "_c12"}, c12, ACC_W'(0));
      check({tag, "_c21"}, c21, ACC_W'(0));
      check({tag, "_c22"}, c22, ACC_W'(0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      tick();
      tick();
      check_reset_outputs("rst_held");
      reset = 1'b1;
   endtask

   initial begin
      reset     = 1'b0;
      out_ready = 1'b1;
      idle();
      tick();
      tick();
      check_reset_outputs("por");
      reset = 1'b1;

      // Skewed matrix with consumer always ready
      drive(1'b1, 16'd19, 1'b0, 16'd0);
      tick();
      check("t1_busy", ACC_W'(busy), ACC_W'(1));
      drive(1'b1, 16'd43, 1'b1, 16'd22);
      tick();
      check("t1_not_valid_yet", ACC_W'(out_valid), ACC_W'(0));
      drive(1'b0, 16'd0, 1'b1, 16'd50);
      push(16'd19, 16'd22, 16'd43, 16'd50);
      tick();
      idle();
      check("t1_busy_hold", ACC_W'(busy), ACC_W'(0));
      compare_front("t1", 1'b1);
      tick();
      check("t1_drop", ACC_W'(out_valid), ACC_W'(0));

      // Backpressure: held for 5 cycles
      out_ready = 1'b0;
      drive(1'b1, 16'd19, 1'b0, 16'd0);
      tick();
      drive(1'b1, 16'd43, 1'b1, 16'd22);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd50);
      push(16'd19, 16'd22, 16'd43, 16'd50);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         compare_front("t2_hold", 1'b0);
         tick();
      end
      out_ready = 1'b1;
      compare_front("t2_accept", 1'b1);
      tick();
      check("t2_drop", ACC_W'(out_valid), ACC_W'(0));
      check("t2_overrun", ACC_W'(overrun), ACC_W'(0));

      // Overrun while held
      out_ready = 1'b0;
      drive(1'b1, 16'd19, 1'b0, 16'd0);
      tick();
      drive(1'b1, 16'd43, 1'b1, 16'd22);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd50);
      push(16'd19, 16'd22, 16'd43, 16'd50);
      tick();
      drive(1'b1, 16'd99, 1'b0, 16'd0);
      tick();
      idle();
      check("t3_overrun", ACC_W'(overrun), ACC_W'(1));
      compare_front("t3_after_drop", 1'b0);
      out_ready = 1'b1;
      compare_front("t3_accept", 1'b1);
      tick();
      check("t3_drop", ACC_W'(out_valid), ACC_W'(0));
      check("t3_overrun_sticky", ACC_W'(overrun), ACC_W'(1));

      do_reset();

      // Back-to-back: accept coincident with the next matrix's first word
      out_ready = 1'b0;
      drive(1'b1, 16'd11, 1'b1, 16'd12);
      tick();
      drive(1'b1, 16'd13, 1'b1, 16'd14);
      push(16'd11, 16'd12, 16'd13, 16'd14);
      tick();
      idle();
      tick();
      compare_front("t4_first", 1'b0);
      out_ready = 1'b1;
      drive(1'b1, 16'd7, 1'b0, 16'd0);
      compare_front("t4_accept", 1'b1);
      tick();
      idle();
      check("t4_busy", ACC_W'(busy), ACC_W'(1));
      check("t4_valid_low", ACC_W'(out_valid), ACC_W'(0));
      check("t4_c11", c11, ACC_W'(7));
      check("t4_overrun", ACC_W'(overrun), ACC_W'(0));
      drive(1'b1, 16'd8, 1'b1, 16'd9);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd10);
      push(16'd7, 16'd9, 16'd8, 16'd10);
      tick();
      idle();
      compare_front("t4_second", 1'b1);
      tick();
      check("t4_overrun_end", ACC_W'(overrun), ACC_W'(0));

      // Reset mid-collect discards the partial matrix
      drive(1'b1, 16'd19, 1'b0, 16'd0);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd22);
      tick();
      idle();
      check("t5_busy", ACC_W'(busy), ACC_W'(1));
      do_reset();
      drive(1'b1, 16'd1, 1'b0, 16'd0);
      tick();
      check("t5_busy_after", ACC_W'(busy), ACC_W'(1));
      check("t5_row0", c11, ACC_W'(1));
      drive(1'b1, 16'd2, 1'b0, 16'd0);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd3);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'd4);
      push(16'd1, 16'd3, 16'd2, 16'd4);
      tick();
      idle();
      compare_front("t5", 1'b1);
      tick();

      // Extra column-1 strobe while collecting
      drive(1'b1, 16'd5, 1'b0, 16'd0);
      tick();
      drive(1'b1, 16'd6, 1'b0, 16'd0);
      tick();
      check("t6_no_overrun_yet", ACC_W'(overrun), ACC_W'(0));
      drive(1'b1, 16'd8, 1'b0, 16'd0);
      tick();
      idle();
      check("t6_overrun", ACC_W'(overrun), ACC_W'(1));
      check("t6_c11", c11, ACC_W'(5));
      check("t6_c21", c21, ACC_W'(6));
      check("t6_busy", ACC_W'(busy), ACC_W'(1));
      drive(1'b0, 16'd0, 1'b1, 16'hFFFF);
      tick();
      drive(1'b0, 16'd0, 1'b1, 16'h8001);
      push(16'd5, 16'hFFFF, 16'd6, 16'h8001);
      tick();
      idle();
      compare_front("t6", 1'b1);
      tick();
      check("t6_drop", ACC_W'(out_valid), ACC_W'(0));
      check("sb_drained", ACC_W'(sb.size()), ACC_W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
